// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write-channel responder.
// Collects AW and W in any order, performs one backend write, then returns B.
// Optional build macro: AXI_WSLAVE_RANGE_CHECK_EN enables address decoding
// against [BASE_ADDR, BASE_ADDR+SIZE); out-of-window writes answer DECERR.
module axi4_lite_write_slave #(
    parameter int          ADDR_W    = 64,
    parameter int          DATA_W    = 64,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter logic [63:0] SIZE      = 64'h0800_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [2:0]          aw_prot,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_valid,
    output logic                w_ready,
    output logic [1:0]          b_resp,
    output logic                b_valid,
    input  logic                b_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_wack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t                state, state_next;
    logic                  aw_held, aw_held_next;
    logic                  w_held, w_held_next;
    logic                  active;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W/8-1:0]   strb_q;
    logic [1:0]            resp_q, resp_next;

    logic                  aw_fire, w_fire;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DATA_W/8-1:0]   cur_strb;
    logic                  in_range;

    // Ready lines come purely from registers; 'active' keeps them low while in reset
    assign aw_ready = active & (state == IDLE) & ~aw_held;
    assign w_ready  = active & (state == IDLE) & ~w_held;
    assign aw_fire  = aw_valid & aw_ready;
    assign w_fire   = w_valid & w_ready;

    assign cur_addr = aw_fire ? aw_addr : addr_q;
    assign cur_strb = w_fire ? w_strb : strb_q;

    assign mem_wen   = (state == WRITE);
    assign mem_waddr = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wdata = data_q;
    assign mem_wstrb = strb_q;
    assign b_valid   = (state == RESP);
    assign b_resp    = resp_q;

`ifdef AXI_WSLAVE_RANGE_CHECK_EN
    logic [64:0] addr_ext;
    assign addr_ext = {{(65-ADDR_W){1'b0}}, cur_addr};
    assign in_range = (addr_ext >= {1'b0, BASE_ADDR}) &&
                      (addr_ext <  ({1'b0, BASE_ADDR} + {1'b0, SIZE}));
`else
    assign in_range = 1'b1;
`endif

    logic unused_cfg;
    assign unused_cfg = ^{BASE_ADDR, SIZE, aw_prot, addr_q[2:0]};

    // State, hold flags, captured payload and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            active  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state   <= state_next;
            aw_held <= aw_held_next;
            w_held  <= w_held_next;
            active  <= 1'b1;
            resp_q  <= resp_next;
            if (aw_fire) begin
                addr_q <= aw_addr;
            end
            if (w_fire) begin
                data_q <= w_data;
                strb_q <= w_strb;
            end
        end
    end

    // Next-state logic: collect both halves, then write or short-circuit to RESP
    always_comb begin
        state_next   = state;
        aw_held_next = aw_held;
        w_held_next  = w_held;
        resp_next    = resp_q;
        case (state)
            IDLE: begin
                aw_held_next = aw_held | aw_fire;
                w_held_next  = w_held | w_fire;
                if ((aw_held | aw_fire) && (w_held | w_fire)) begin
                    if (!in_range) begin
                        state_next = RESP;
                        resp_next  = RESP_DECERR;
                    end else if (cur_strb == '0) begin
                        state_next = RESP;
                        resp_next  = RESP_OKAY;
                    end else begin
                        state_next = WRITE;
                        resp_next  = RESP_OKAY;
                    end
                end
            end
            WRITE: begin
                if (mem_wack) begin
                    state_next = RESP;
                    resp_next  = RESP_OKAY;
                end
            end
            RESP: begin
                if (b_ready) begin
                    state_next   = IDLE;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// Directed self-checking bench for axi4_lite_write_slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4_lite_write_slave;

    logic        clk;
    logic        rst;
    logic [63:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_wack;

    int checks;
    int failures;
    int wen_cycles;

    axi4_lite_write_slave dut (
        .clk       (clk),
        .rst       (rst),
        .aw_addr   (aw_addr),
        .aw_prot   (aw_prot),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_resp    (b_resp),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_wack  (mem_wack)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count cycles in which the backend write request is high
    always @(posedge clk) begin
        if (mem_wen === 1'b1) begin
            wen_cycles++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic awv, input logic [63:0] addr,
                                  input logic wv, input logic [63:0] data,
                                  input logic [7:0] strb);
        aw_valid = awv;
        aw_addr  = addr;
        w_valid  = wv;
        w_data   = data;
        w_strb   = strb;
    endtask

    task automatic idle_inputs();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        wen_cycles = 0;
        rst        = 1'b1;
        aw_addr    = '0;
        aw_prot    = 3'b010;
        aw_valid   = 1'b0;
        w_data     = '0;
        w_strb     = '0;
        w_valid    = 1'b0;
        b_ready    = 1'b0;
        mem_wack   = 1'b0;

        // Reset state
        tick();
        tick();
        check_output("rst_aw_ready", 64'(aw_ready), 64'd0);
        check_output("rst_w_ready", 64'(w_ready), 64'd0);
        check_output("rst_b_valid", 64'(b_valid), 64'd0);
        check_output("rst_b_resp", 64'(b_resp), 64'd0);
        check_output("rst_mem_wen", 64'(mem_wen), 64'd0);
        check_output("rst_mem_waddr", mem_waddr, 64'd0);
        check_output("rst_mem_wdata", mem_wdata, 64'd0);
        check_output("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        rst = 1'b0;
        tick();
        check_output("post_rst_aw_ready", 64'(aw_ready), 64'd1);
        check_output("post_rst_w_ready", 64'(w_ready), 64'd1);

        // Simultaneous AW and W, minimum latency
        $display("[TB] simultaneous AW/W");
        wen_cycles = 0;
        apply_stimulus(1'b1, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF);
        tick();
        idle_inputs();
        check_output("sim_mem_wen", 64'(mem_wen), 64'd1);
        check_output("sim_mem_waddr", mem_waddr, 64'h8000_0010);
        check_output("sim_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        check_output("sim_mem_wstrb", 64'(mem_wstrb), 64'hFF);
        check_output("sim_aw_ready", 64'(aw_ready), 64'd0);
        check_output("sim_w_ready", 64'(w_ready), 64'd0);
        check_output("sim_b_valid_early", 64'(b_valid), 64'd0);
        mem_wack = 1'b1;
        tick();
        mem_wack = 1'b0;
        check_output("sim_mem_wen_drop", 64'(mem_wen), 64'd0);
        check_output("sim_b_valid", 64'(b_valid), 64'd1);
        check_output("sim_b_resp", 64'(b_resp), 64'd0);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_output("sim_b_valid_drop", 64'(b_valid), 64'd0);
        check_output("sim_aw_ready_back", 64'(aw_ready), 64'd1);
        check_output("sim_w_ready_back", 64'(w_ready), 64'd1);
        check_output("sim_wen_cycles", 64'(wen_cycles), 64'd1);

        // W arrives three cycles before AW
        $display("[TB] W before AW");
        wen_cycles = 0;
        apply_stimulus(1'b0, 64'h0, 1'b1, 64'hA5A5_0000_1234_5678, 8'h0F);
        tick();
        idle_inputs();
        check_output("wfirst_w_ready", 64'(w_ready), 64'd0);
        check_output("wfirst_aw_ready", 64'(aw_ready), 64'd1);
        check_output("wfirst_mem_wen_idle", 64'(mem_wen), 64'd0);
        tick();
        tick();
        check_output("wfirst_w_ready_hold", 64'(w_ready), 64'd0);
        apply_stimulus(1'b1, 64'h8000_0104, 1'b0, 64'h0, 8'h00);
        tick();
        idle_inputs();
        check_output("wfirst_mem_wen", 64'(mem_wen), 64'd1);
        check_output("wfirst_mem_waddr", mem_waddr, 64'h8000_0100);
        check_output("wfirst_mem_wdata", mem_wdata, 64'hA5A5_0000_1234_5678);
        check_output("wfirst_mem_wstrb", 64'(mem_wstrb), 64'h0F);
        mem_wack = 1'b1;
        tick();
        mem_wack = 1'b0;
        check_output("wfirst_b_valid", 64'(b_valid), 64'd1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_output("wfirst_wen_cycles", 64'(wen_cycles), 64'd1);

        // Backend and response backpressure
        $display("[TB] backpressure");
        wen_cycles = 0;
        apply_stimulus(1'b1, 64'h8000_0020, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            check_output("bp_mem_wen_hold", 64'(mem_wen), 64'd1);
            check_output("bp_mem_wdata_hold", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
            check_output("bp_aw_ready_wr", 64'(aw_ready), 64'd0);
            check_output("bp_w_ready_wr", 64'(w_ready), 64'd0);
            if (i == 4) begin
                mem_wack = 1'b1;
            end
            tick();
        end
        mem_wack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("bp_b_valid_hold", 64'(b_valid), 64'd1);
            check_output("bp_b_resp_hold", 64'(b_resp), 64'd0);
            check_output("bp_aw_ready_resp", 64'(aw_ready), 64'd0);
            check_output("bp_mem_wen_off", 64'(mem_wen), 64'd0);
            if (i == 3) begin
                b_ready = 1'b1;
            end
            tick();
        end
        b_ready = 1'b0;
        check_output("bp_b_valid_drop", 64'(b_valid), 64'd0);
        check_output("bp_aw_ready_back", 64'(aw_ready), 64'd1);
        check_output("bp_wen_cycles", 64'(wen_cycles), 64'd5);

        // All-zero strobe skips the backend
        $display("[TB] zero strobe");
        wen_cycles = 0;
        apply_stimulus(1'b1, 64'h8000_0030, 1'b1, 64'h5555_5555_5555_5555, 8'h00);
        tick();
        idle_inputs();
        check_output("zs_mem_wen", 64'(mem_wen), 64'd0);
        check_output("zs_b_valid", 64'(b_valid), 64'd1);
        check_output("zs_b_resp", 64'(b_resp), 64'd0);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_output("zs_wen_cycles", 64'(wen_cycles), 64'd0);
        check_output("zs_aw_ready_back", 64'(aw_ready), 64'd1);

        // Address outside the decoded window
        $display("[TB] range check");
        wen_cycles = 0;
        apply_stimulus(1'b1, 64'h1000_0000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        tick();
        idle_inputs();
`ifdef AXI_WSLAVE_RANGE_CHECK_EN
        check_output("rc_mem_wen", 64'(mem_wen), 64'd0);
        check_output("rc_b_valid", 64'(b_valid), 64'd1);
        check_output("rc_b_resp", 64'(b_resp), 64'd3);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_output("rc_wen_cycles", 64'(wen_cycles), 64'd0);
`else
        check_output("rc_mem_wen", 64'(mem_wen), 64'd1);
        check_output("rc_mem_waddr", mem_waddr, 64'h1000_0000);
        mem_wack = 1'b1;
        tick();
        mem_wack = 1'b0;
        check_output("rc_b_valid", 64'(b_valid), 64'd1);
        check_output("rc_b_resp", 64'(b_resp), 64'd0);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_output("rc_wen_cycles", 64'(wen_cycles), 64'd1);
`endif
        check_output("rc_b_valid_drop", 64'(b_valid), 64'd0);

        // Reset while the backend write is in flight
        $display("[TB] reset mid-operation");
        apply_stimulus(1'b1, 64'h8000_0040, 1'b1, 64'h7777_8888_9999_AAAA, 8'hF0);
        tick();
        idle_inputs();
        check_output("mr_mem_wen", 64'(mem_wen), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("mr_mem_wen_drop", 64'(mem_wen), 64'd0);
        check_output("mr_b_valid", 64'(b_valid), 64'd0);
        check_output("mr_aw_ready_in_rst", 64'(aw_ready), 64'd0);
        mem_wack = 1'b1;
        tick();
        mem_wack = 1'b0;
        check_output("mr_aw_ready_after", 64'(aw_ready), 64'd1);
        check_output("mr_w_ready_after", 64'(w_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check_output("mr_no_b_valid", 64'(b_valid), 64'd0);
            check_output("mr_no_mem_wen", 64'(mem_wen), 64'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
